// File: rtl/dma_pkg.sv
// Shared constants, state encoding and register write order for the DMA sequencer.
package dma_pkg;

    localparam int unsigned NUM_REGS   = 9;
    localparam int unsigned DESC_W     = 8 * NUM_REGS;
    localparam int unsigned PROG_STEPS = 8;

    // DMA port register indices (bit position in dmaport_wr, byte lane in a descriptor)
    localparam logic [3:0] REG_SADDRL = 4'd0;
    localparam logic [3:0] REG_SADDRH = 4'd1;
    localparam logic [3:0] REG_SADDRX = 4'd2;
    localparam logic [3:0] REG_DADDRL = 4'd3;
    localparam logic [3:0] REG_DADDRH = 4'd4;
    localparam logic [3:0] REG_DADDRX = 4'd5;
    localparam logic [3:0] REG_LEN    = 4'd6;
    localparam logic [3:0] REG_CTRL   = 4'd7;
    localparam logic [3:0] REG_NUM    = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PROG      = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_ACT  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    // Register written in each PROG step; CTRL is held back for the LAUNCH cycle
    function automatic logic [3:0] prog_reg(input logic [2:0] step);
        logic [3:0] r;
        case (step)
            3'd0:    r = REG_SADDRL;
            3'd1:    r = REG_SADDRH;
            3'd2:    r = REG_SADDRX;
            3'd3:    r = REG_DADDRL;
            3'd4:    r = REG_DADDRH;
            3'd5:    r = REG_DADDRX;
            3'd6:    r = REG_LEN;
            default: r = REG_NUM;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module dma_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant_c
);

    logic last_q;

    // Grant decode: single request always wins, tie resolved against last grant
    always_comb begin
        grant_c = 2'b00;
        if (en) begin
            grant_c[0] = req[0] & (~req[1] | last_q);
            grant_c[1] = req[1] & (~req[0] | ~last_q);
        end
    end

    // Last-granted register; resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (|grant_c) begin
            last_q <= grant_c[1];
        end
    end

endmodule

// File: rtl/dma_sequencer.sv
// Serves two descriptor requesters by programming the DMA port registers and
// waiting for the engine to finish, with a watchdog on the completion phase.
module dma_sequencer
    import dma_pkg::*;
#(
    parameter int unsigned TOUT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req0_valid,
    input  logic                req1_valid,
    input  logic [DESC_W-1:0]   req0_desc,
    input  logic [DESC_W-1:0]   req1_desc,
    output logic                req0_ready,
    output logic                req1_ready,
    output logic                req0_done,
    output logic                req1_done,
    output logic [NUM_REGS-1:0] dmaport_wr,
    output logic [7:0]          dma_zdata,
    input  logic                dma_act,
    output logic                busy,
    output logic                owner,
    output logic                tout_err,
    input  logic                err_clr
);

    state_t              state_q, state_d;
    logic [2:0]          step_q, step_d;
    logic [DESC_W-1:0]   desc_q, desc_d;
    logic                owner_q, owner_d;
    logic                busy_q;
    logic [NUM_REGS-1:0] wr_q, wr_d;
    logic [7:0]          zdata_q, zdata_d;
    logic [TOUT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic                tout_err_q, tout_err_d;
    logic                grant_en, set_err;
    logic [1:0]          grant;
    logic [1:0]          done_c;
    logic [3:0]          wr_reg;

    dma_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (grant_en),
        .req     ({req1_valid, req0_valid}),
        .grant_c (grant)
    );

    // Next state, watchdog, and the strobe that belongs to the cycle being entered
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        desc_d   = desc_q;
        owner_d  = owner_q;
        cnt_d    = '0;
        grant_en = 1'b0;
        set_err  = 1'b0;
        done_c   = 2'b00;
        wr_d     = '0;
        zdata_d  = '0;
        wr_reg   = REG_SADDRL;
        cnt_inc  = cnt_q + TOUT_W'(1);

        case (state_q)
            ST_IDLE: begin
                grant_en = ~dma_act & reset_n;
                if (|grant) begin
                    state_d = ST_PROG;
                    step_d  = 3'd0;
                    owner_d = grant[1];
                    desc_d  = grant[1] ? req1_desc : req0_desc;
                end
            end
            ST_PROG: begin
                if (step_q == 3'(PROG_STEPS - 1)) begin
                    state_d = ST_LAUNCH;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_ACT;
            end
            ST_WAIT_ACT, ST_WAIT_DONE: begin
                cnt_d = cnt_inc;
                if (state_q == ST_WAIT_ACT && dma_act) begin
                    state_d = ST_WAIT_DONE;
                end
                if (state_q == ST_WAIT_DONE && !dma_act) begin
                    state_d         = ST_IDLE;
                    done_c[owner_q] = 1'b1;
                end else if (&cnt_inc) begin
                    state_d         = ST_IDLE;
                    done_c[owner_q] = 1'b1;
                    set_err         = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_PROG || state_d == ST_LAUNCH) begin
            wr_reg  = (state_d == ST_LAUNCH) ? REG_CTRL : prog_reg(step_d);
            wr_d    = NUM_REGS'(1) << wr_reg;
            zdata_d = desc_d[{wr_reg, 3'b000} +: 8];
        end

        if (set_err) begin
            tout_err_d = 1'b1;
        end else if (err_clr) begin
            tout_err_d = 1'b0;
        end else begin
            tout_err_d = tout_err_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            step_q     <= 3'd0;
            desc_q     <= '0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            wr_q       <= '0;
            zdata_q    <= '0;
            cnt_q      <= '0;
            tout_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            desc_q     <= desc_d;
            owner_q    <= owner_d;
            busy_q     <= (state_d != ST_IDLE);
            wr_q       <= wr_d;
            zdata_q    <= zdata_d;
            cnt_q      <= cnt_d;
            tout_err_q <= tout_err_d;
        end
    end

    // Accept and completion pulses are decided in the cycle they occur
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign req0_done  = done_c[0];
    assign req1_done  = done_c[1];
    assign dmaport_wr = wr_q;
    assign dma_zdata  = zdata_q;
    assign busy       = busy_q;
    assign owner      = owner_q;
    assign tout_err   = tout_err_q;

endmodule

// File: tb/tb_dma_sequencer.sv
// Directed bench for dma_sequencer: cycle table for one full transfer plus
// hand sequences for arbitration, foreign-DMA blocking, watchdog and reset.
module tb_dma_sequencer;

    logic        clk, reset_n;
    logic        v0, v1, act, clr;
    logic [71:0] desc0, desc1;
    logic        r0, r1, d0, d1, busy, owner, terr;
    logic [8:0]  wr;
    logic [7:0]  zd;

    logic        w_v0, w_v1, w_act, w_clr;
    logic        w_r0, w_r1, w_d0, w_d1, w_busy, w_owner, w_terr;
    logic [8:0]  w_wr;
    logic [7:0]  w_zd;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [23:0] M_ALL  = 24'hFFFFFF;
    localparam logic [23:0] M_RDY  = 24'hC00000;
    localparam logic [23:0] M_DONE = 24'h300000;
    localparam logic [23:0] M_BUSY = 24'h080000;
    localparam logic [23:0] M_OWN  = 24'h040000;
    localparam logic [23:0] M_TERR = 24'h020000;
    localparam logic [23:0] M_WRD  = 24'h01FFFF;

    dma_sequencer u_dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(v0), .req1_valid(v1), .req0_desc(desc0), .req1_desc(desc1),
        .req0_ready(r0), .req1_ready(r1), .req0_done(d0), .req1_done(d1),
        .dmaport_wr(wr), .dma_zdata(zd), .dma_act(act),
        .busy(busy), .owner(owner), .tout_err(terr), .err_clr(clr)
    );

    dma_sequencer #(.TOUT_W(4)) u_wd (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(w_v0), .req1_valid(w_v1), .req0_desc(desc0), .req1_desc(desc1),
        .req0_ready(w_r0), .req1_ready(w_r1), .req0_done(w_d0), .req1_done(w_d1),
        .dmaport_wr(w_wr), .dma_zdata(w_zd), .dma_act(w_act),
        .busy(w_busy), .owner(w_owner), .tout_err(w_terr), .err_clr(w_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic        v1;
        logic        act;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [23:0] mk(input logic er0, input logic er1, input logic ed0,
                                       input logic ed1, input logic eb, input logic eo,
                                       input logic et, input logic [8:0] ew, input logic [7:0] edat);
        return {er0, er1, ed0, ed1, eb, eo, et, ew, edat};
    endfunction

    function automatic logic [23:0] obs();
        return {r0, r1, d0, d1, busy, owner, terr, wr, zd};
    endfunction

    function automatic logic [23:0] w_obs();
        return {w_r0, w_r1, w_d0, w_d1, w_busy, w_owner, w_terr, w_wr, w_zd};
    endfunction

    task automatic chkm(input string nm, input logic [23:0] got, input logic [23:0] mask,
                        input logic [23:0] exp);
        n_cmp++;
        if ((got & mask) !== (exp & mask)) begin
            n_err++;
            $display("FAIL %s: got %h required %h (mask %h)", nm, got & mask, exp & mask, mask);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Runs one service from the first PROG cycle through the done cycle
    task automatic serve(input logic who, input int delay, input int len);
        for (int k = 1; k <= 9; k++) begin
            act = 1'b0;
            @(negedge clk);
            chkm($sformatf("serve%0d_prog%0d", who, k), obs(), M_RDY | M_DONE | M_BUSY | M_OWN,
                 mk(0, 0, 0, 0, 1, who, 0, 0, 0));
            next();
        end
        for (int k = 0; k < delay + len; k++) begin
            act = (k >= delay);
            @(negedge clk);
            chkm($sformatf("serve%0d_wait%0d", who, k), obs(), M_RDY | M_DONE | M_BUSY | M_WRD,
                 mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
            next();
        end
        act = 1'b0;
        @(negedge clk);
        chkm($sformatf("serve%0d_done", who), obs(), M_RDY | M_DONE | M_BUSY | M_OWN,
             mk(0, 0, ~who, who, 1, who, 0, 0, 0));
        next();
    endtask

    initial begin
        int ord[8];
        ord   = '{0, 1, 2, 3, 4, 5, 6, 8};
        desc0 = 72'h18_17_16_15_14_13_12_11_10;
        desc1 = 72'h28_27_26_25_24_23_22_21_20;
        v0 = 0; v1 = 0; act = 0; clr = 0;
        w_v0 = 0; w_v1 = 0; w_act = 0; w_clr = 0;

        // Reset state, with a request pending to show ready is held off
        reset_n = 1'b0;
        v0 = 1'b1;
        @(negedge clk);
        chkm("reset_main", obs(), M_ALL, 24'h0);
        chkm("reset_wd", w_obs(), M_ALL, 24'h0);
        next();
        reset_n = 1'b1;

        // Single req0 transfer, cycle by cycle
        tbl.push_back('{1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 9'h0, 8'h0)});
        for (int i = 0; i < 8; i++) begin
            logic [8:0] w;
            w = 9'h1 << ord[i];
            tbl.push_back('{0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, w, 8'(8'h10 + ord[i]))});
        end
        tbl.push_back('{0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 9'h080, 8'h17)});
        tbl.push_back('{0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 9'h0, 8'h0)});
        for (int i = 0; i < 20; i++)
            tbl.push_back('{0, 0, 1, mk(0, 0, 0, 0, 1, 0, 0, 9'h0, 8'h0)});
        tbl.push_back('{0, 0, 0, mk(0, 0, 1, 0, 1, 0, 0, 9'h0, 8'h0)});
        tbl.push_back('{0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 9'h0, 8'h0)});

        for (int i = 0; i < tbl.size(); i++) begin
            v0 = tbl[i].v0; v1 = tbl[i].v1; act = tbl[i].act;
            @(negedge clk);
            chkm($sformatf("xfer0_cyc%0d", i), obs(), M_ALL, tbl[i].exp);
            next();
        end

        // Both valid from reset: req0 first, req1 only after req0's done
        reset_n = 1'b0;
        @(negedge clk);
        chkm("reset2", obs(), M_ALL, 24'h0);
        next();
        reset_n = 1'b1;
        v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        chkm("tie_first", obs(), M_RDY, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        next();
        v0 = 1'b0;
        serve(1'b0, 2, 5);
        @(negedge clk);
        chkm("tie_second", obs(), M_RDY | M_OWN | M_BUSY, mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        next();
        v1 = 1'b0;
        serve(1'b1, 1, 3);

        // Foreign DMA activity blocks grants until it drops
        act = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chkm($sformatf("blocked%0d", k), obs(), M_RDY | M_BUSY | M_WRD, 24'h0);
            next();
        end
        act = 1'b0;
        @(negedge clk);
        chkm("unblocked", obs(), M_RDY, mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        next();
        v1 = 1'b0;
        serve(1'b1, 1, 2);

        // Watchdog on the TOUT_W=4 instance: engine never starts
        w_v0 = 1'b1;
        @(negedge clk);
        chkm("wd_grant", w_obs(), M_RDY, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        next();
        w_v0 = 1'b0;
        for (int k = 0; k < 8; k++) next();
        @(negedge clk);
        chkm("wd_launch", w_obs(), M_WRD, mk(0, 0, 0, 0, 0, 0, 0, 9'h080, 8'h17));
        next();
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            chkm($sformatf("wd_wait%0d", k), w_obs(), M_DONE | M_BUSY | M_TERR,
                 mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
            next();
        end
        w_clr = 1'b1;
        @(negedge clk);
        chkm("wd_done", w_obs(), M_DONE | M_BUSY, mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
        next();
        w_clr = 1'b0;
        @(negedge clk);
        chkm("wd_err_set", w_obs(), M_DONE | M_BUSY | M_TERR, mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        next();
        w_clr = 1'b1;
        @(negedge clk);
        chkm("wd_err_held", w_obs(), M_TERR, mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        next();
        w_clr = 1'b0;
        @(negedge clk);
        chkm("wd_err_clr", w_obs(), M_TERR, 24'h0);
        next();

        // Reset mid-PROG abandons the transfer and restores req0 priority
        reset_n = 1'b0; v1 = 1'b1;
        @(negedge clk);
        chkm("reset3", obs(), M_ALL, 24'h0);
        next();
        reset_n = 1'b1; v1 = 1'b0; v0 = 1'b1;
        @(negedge clk);
        chkm("pre_abort_grant", obs(), M_RDY, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        next();
        v0 = 1'b0;
        for (int k = 0; k < 3; k++) next();
        reset_n = 1'b0; v0 = 1'b1; v1 = 1'b1;
        #1;
        chkm("abort_immediate", obs(), M_ALL, 24'h0);
        @(negedge clk);
        chkm("abort_zero", obs(), M_ALL, 24'h0);
        next();
        @(negedge clk);
        chkm("abort_no_done", obs(), M_ALL, 24'h0);
        next();
        reset_n = 1'b1;
        @(negedge clk);
        chkm("post_abort_tie", obs(), M_RDY, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        next();
        v0 = 1'b0; v1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
